// File: rtl/hit_event_controller_pkg.sv
// Shared types and constants for the hit/score game controller.
// Also holds the saturating score adder used by the controller.
package game_pkg;

  localparam int unsigned LIVES_W            = 3;
  localparam int unsigned SCORE_W            = 16;
  localparam int unsigned ROPE_POINTS_DEF    = 10;
  localparam int unsigned PRESENT_POINTS_DEF = 50;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    INVULN    = 2'd1,
    GAME_OVER = 2'd2
  } game_state_e;

  // The sum is formed one bit wider so a carry out means the score must clamp.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W:0]   inc);
    logic [SCORE_W:0] sum;
    sum = {1'b0, a} + inc;
    return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/hit_event_controller_if.sv
// Frame tick, restart, collision levels and game status outputs of the controller.
interface hit_event_controller_if;
  import game_pkg::*;

  logic               startOfFrame;
  logic               restart;
  logic               col_player_ball1;
  logic               col_rope_ball1;
  logic               col_present;
  logic [LIVES_W-1:0] lives;
  logic [SCORE_W-1:0] score;
  logic               player_hit_pulse;
  logic               ball_hit_pulse;
  logic               present_take_pulse;
  logic               invulnerable;
  logic               game_over;

  modport master (
    output startOfFrame, restart, col_player_ball1, col_rope_ball1, col_present,
    input  lives, score, player_hit_pulse, ball_hit_pulse, present_take_pulse,
           invulnerable, game_over
  );

  modport slave (
    input  startOfFrame, restart, col_player_ball1, col_rope_ball1, col_present,
    output lives, score, player_hit_pulse, ball_hit_pulse, present_take_pulse,
           invulnerable, game_over
  );

endinterface

// File: rtl/hit_event_controller_frame_event_latch.sv
// Sticky per-frame capture of a collision level; cleared at frame evaluation.
module frame_event_latch (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic event_i,
  output logic flag
);

  logic flag_q;
  logic flag_d;

  always_comb begin
    flag_d = flag_q;
    if (clear) begin
      flag_d = 1'b0;
    end else if (event_i) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/hit_event_controller.sv
// Per-frame collision evaluation: lives, score, invulnerability window and game over.
module hit_event_controller
  import game_pkg::*;
#(
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned MAX_LIVES      = 5,
  parameter int unsigned INVULN_FRAMES  = 60,
  parameter int unsigned ROPE_POINTS    = ROPE_POINTS_DEF,
  parameter int unsigned PRESENT_POINTS = PRESENT_POINTS_DEF
) (
  input  logic                   clk,
  input  logic                   resetN,
  hit_event_controller_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(INVULN_FRAMES + 1);
  localparam int unsigned INC_W = SCORE_W + 1;

  game_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               ph_q, ph_d;
  logic               bh_q, bh_d;
  logic               pt_q, pt_d;

  logic               clear;
  logic               flag_player, flag_rope, flag_present;
  logic               ev_player, ev_rope, ev_present;
  logic [INC_W-1:0]   inc;
  logic [LIVES_W-1:0] lives_inc;

  // Restart also flushes the sticky flags so nothing leaks into the new game.
  assign clear = bus.restart | bus.startOfFrame;

  frame_event_latch u_latch_player (
    .clk(clk), .resetN(resetN), .clear(clear),
    .event_i(bus.col_player_ball1), .flag(flag_player)
  );

  frame_event_latch u_latch_rope (
    .clk(clk), .resetN(resetN), .clear(clear),
    .event_i(bus.col_rope_ball1), .flag(flag_rope)
  );

  frame_event_latch u_latch_present (
    .clk(clk), .resetN(resetN), .clear(clear),
    .event_i(bus.col_present), .flag(flag_present)
  );

  assign ev_player  = flag_player  | bus.col_player_ball1;
  assign ev_rope    = flag_rope    | bus.col_rope_ball1;
  assign ev_present = flag_present | bus.col_present;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lives_d   = lives_q;
    score_d   = score_q;
    ph_d      = 1'b0;
    bh_d      = 1'b0;
    pt_d      = 1'b0;
    inc       = '0;
    lives_inc = lives_q;

    if (bus.restart) begin
      state_d = PLAY;
      cnt_d   = '0;
      lives_d = LIVES_W'(LIVES_INIT);
      score_d = '0;
    end else if (bus.startOfFrame && (state_q != GAME_OVER)) begin
      inc     = (ev_rope    ? INC_W'(ROPE_POINTS)    : '0)
              + (ev_present ? INC_W'(PRESENT_POINTS) : '0);
      score_d = sat_add(score_q, inc);
      bh_d    = ev_rope;
      pt_d    = ev_present;

      // Present is credited before a hit is charged, so a last life can be saved.
      if (ev_present && (lives_q < LIVES_W'(MAX_LIVES))) begin
        lives_inc = lives_q + 1'b1;
      end
      lives_d = lives_inc;

      if ((state_q == PLAY) && ev_player) begin
        lives_d = lives_inc - 1'b1;
        ph_d    = 1'b1;
        if (lives_d == '0) begin
          state_d = GAME_OVER;
        end else begin
          state_d = INVULN;
          cnt_d   = CNT_W'(INVULN_FRAMES);
        end
      end else if (state_q == INVULN) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          state_d = PLAY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= PLAY;
      cnt_q   <= '0;
      lives_q <= LIVES_W'(LIVES_INIT);
      score_q <= '0;
      ph_q    <= 1'b0;
      bh_q    <= 1'b0;
      pt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lives_q <= lives_d;
      score_q <= score_d;
      ph_q    <= ph_d;
      bh_q    <= bh_d;
      pt_q    <= pt_d;
    end
  end

  assign bus.lives              = lives_q;
  assign bus.score              = score_q;
  assign bus.player_hit_pulse   = ph_q;
  assign bus.ball_hit_pulse     = bh_q;
  assign bus.present_take_pulse = pt_q;
  assign bus.invulnerable       = (state_q == INVULN);
  assign bus.game_over          = (state_q == GAME_OVER);

endmodule

// File: tb/tb_hit_event_controller.sv
// Scoreboard bench for hit_event_controller: a behavioural game model queues expected outputs.
module tb_hit_event_controller;
  import game_pkg::*;

  typedef struct packed {
    logic [2:0]  lives;
    logic [15:0] score;
    logic        ph;
    logic        bh;
    logic        pt;
    logic        inv;
    logic        go;
  } obs_t;

  logic clk = 1'b0;
  logic resetN;

  always #5 clk = ~clk;

  hit_event_controller_if bus ();

  hit_event_controller #(
    .LIVES_INIT(3),
    .MAX_LIVES(5),
    .INVULN_FRAMES(60),
    .ROPE_POINTS(10),
    .PRESENT_POINTS(50)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus.slave)
  );

  obs_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Behavioural model state: 0 = PLAY, 1 = INVULN, 2 = GAME_OVER
  int m_lives, m_score, m_state, m_cnt;

  function automatic obs_t observe();
    obs_t o;
    o.lives = bus.lives;
    o.score = bus.score;
    o.ph    = bus.player_hit_pulse;
    o.bh    = bus.ball_hit_pulse;
    o.pt    = bus.present_take_pulse;
    o.inv   = bus.invulnerable;
    o.go    = bus.game_over;
    return o;
  endfunction

  function automatic obs_t model_snapshot();
    obs_t e;
    e       = '0;
    e.lives = 3'(m_lives);
    e.score = 16'(m_score);
    e.inv   = (m_state == 1);
    e.go    = (m_state == 2);
    return e;
  endfunction

  task automatic model_reset();
    m_lives = 3;
    m_score = 0;
    m_state = 0;
    m_cnt   = 0;
    sb.push_back(model_snapshot());
  endtask

  task automatic model_eval(input bit r, input bit p, input bit h);
    obs_t e;
    int   lp;
    bit   hit_taken;
    hit_taken = 1'b0;
    if (m_state != 2) begin
      m_score = m_score + (r ? 10 : 0) + (p ? 50 : 0);
      if (m_score > 65535) m_score = 65535;
      lp = m_lives;
      if (p && lp < 5) lp = lp + 1;
      if (m_state == 0 && h) begin
        lp = lp - 1;
        hit_taken = 1'b1;
        if (lp == 0) m_state = 2;
        else begin
          m_state = 1;
          m_cnt   = 60;
        end
      end else if (m_state == 1) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_state = 0;
      end
      m_lives = lp;
    end
    e = model_snapshot();
    if (m_state != 2 || hit_taken) begin
      e.bh = r;
      e.pt = p;
      e.ph = hit_taken;
    end
    sb.push_back(e);
  endtask

  task automatic drive_col(input bit r, input bit p, input bit h);
    bus.col_rope_ball1   = r;
    bus.col_present      = p;
    bus.col_player_ball1 = h;
  endtask

  task automatic pop_compare(input string name);
    obs_t a, e;
    a = observe();
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty, got %h", name, a);
    end else begin
      e = sb.pop_front();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got lives=%0d score=%h ph/bh/pt=%b%b%b inv=%b go=%b, need lives=%0d score=%h ph/bh/pt=%b%b%b inv=%b go=%b",
                 name, a.lives, a.score, a.ph, a.bh, a.pt, a.inv, a.go,
                 e.lives, e.score, e.ph, e.bh, e.pt, e.inv, e.go);
      end
    end
  endtask

  // Collisions held for `hold` cycles, then a frame tick (optionally with collision still high).
  task automatic run_frame(input bit r, input bit p, input bit h, input int hold,
                           input bit on_sof, input string name);
    bit seen;
    logic [2:0] pulses;
    seen = (hold > 0) || on_sof;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      drive_col(r, p, h);
    end
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    if (on_sof) drive_col(r, p, h);
    else        drive_col(1'b0, 1'b0, 1'b0);
    model_eval(seen & r, seen & p, seen & h);
    @(posedge clk);
    #1;
    pop_compare(name);
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    drive_col(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    pulses = {bus.player_hit_pulse, bus.ball_hit_pulse, bus.present_take_pulse};
    vectors++;
    if (pulses !== 3'b000) begin
      miscompares++;
      $display("FAIL %s_pulse_width: pulses=%b, need 000", name, pulses);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.restart      = 1'b0;
    drive_col(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    pop_compare("reset");
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_rope_hold();
    run_frame(1'b1, 1'b0, 1'b0, 100, 1'b0, "rope_hold");
  endtask

  task automatic test_sof_current();
    run_frame(1'b1, 1'b0, 1'b0, 0, 1'b1, "rope_on_sof");
    run_frame(1'b0, 1'b0, 1'b0, 2, 1'b0, "no_carry");
  endtask

  task automatic test_player_invuln();
    run_frame(1'b0, 1'b0, 1'b1, 2, 1'b0, "player_hit");
    for (int i = 0; i < 60; i++) run_frame(1'b0, 1'b0, 1'b1, 2, 1'b0, "invuln_hits");
  endtask

  task automatic test_present_player();
    run_frame(1'b0, 1'b0, 1'b1, 1, 1'b0, "hit_to_one");
    for (int i = 0; i < 60; i++) run_frame(1'b0, 1'b0, 1'b0, 1, 1'b0, "invuln_wait1");
    run_frame(1'b0, 1'b1, 1'b1, 1, 1'b0, "present_and_hit");
    for (int i = 0; i < 60; i++) run_frame(1'b0, 1'b0, 1'b0, 1, 1'b0, "invuln_wait2");
    run_frame(1'b0, 1'b0, 1'b1, 1, 1'b0, "last_life");
    run_frame(1'b1, 1'b0, 1'b0, 3, 1'b0, "gameover_rope");
    run_frame(1'b1, 1'b1, 1'b1, 1, 1'b1, "gameover_all");
  endtask

  task automatic test_restart();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_col(1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive_col(1'b0, 1'b0, 1'b0);
    bus.restart      = 1'b1;
    bus.startOfFrame = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    pop_compare("restart_with_sof");
    @(negedge clk);
    bus.restart      = 1'b0;
    bus.startOfFrame = 1'b0;
    run_frame(1'b0, 1'b0, 1'b0, 1, 1'b0, "after_restart");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 1310; i++) run_frame(1'b0, 1'b1, 1'b0, 1, 1'b0, "present_run");
    run_frame(1'b1, 1'b0, 1'b0, 1, 1'b0, "rope_to_fff0_a");
    run_frame(1'b1, 1'b0, 1'b0, 1, 1'b0, "rope_to_fff0_b");
    run_frame(1'b1, 1'b1, 1'b0, 1, 1'b0, "score_saturate");
  endtask

  task automatic test_reset_invuln();
    run_frame(1'b0, 1'b0, 1'b1, 1, 1'b0, "hit_before_reset");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_col(1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    drive_col(1'b0, 1'b0, 1'b0);
    resetN = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    pop_compare("reset_mid_invuln");
    @(negedge clk);
    resetN = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0, 1, 1'b0, "post_reset_frame");
  endtask

  initial begin
    test_reset();
    test_rope_hold();
    test_sof_current();
    test_player_invuln();
    test_present_player();
    test_restart();
    test_saturation();
    test_reset_invuln();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: %0d entries, need 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
